// File: rtl/pen_locator_pkg.sv
// rtl/pen_locator_pkg.sv - shared constants, types and helpers for the light-pen tracker
package pen_locator_pkg;

  localparam int PEN_DELAY_DEF = 4;
  localparam int CONFIRM_DEF   = 3;

  localparam int LIT_BIT   = 3;
  localparam int GREEN_BIT = 2;
  localparam int RED_BIT   = 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_TRACK = 2'd1,
    S_WRITE = 2'd2
  } state_t;

  typedef struct packed {
    logic       valid;
    logic [5:0] pos;
  } pos_t;

  typedef struct packed {
    logic       ok;
    logic [2:0] idx;
  } oh_t;

  // ok is set only for exactly one bit high
  function automatic oh_t oh_encode(input logic [7:0] v);
    oh_t r;
    r.ok  = (v != 8'h00) && ((v & (v - 8'h01)) == 8'h00);
    r.idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (v[i]) r.idx = 3'(i);
    end
    return r;
  endfunction

  function automatic logic [3:0] ram_word(input logic erase, input logic [1:0] color);
    logic [3:0] w;
    w = 4'b0000;
    if (!erase) begin
      w[LIT_BIT]   = 1'b1;
      w[GREEN_BIT] = color[1];
      w[RED_BIT]   = color[0];
    end
    return w;
  endfunction

endpackage

// File: rtl/pen_pos_delay.sv
// rtl/pen_pos_delay.sv - shift register aligning {valid, pos} with the synchronised pen sample
module pen_pos_delay
  import pen_locator_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr_i,
  input  logic [6:0] din_i,
  output logic [6:0] dout_o
);

  generate
    if (DEPTH == 0) begin : g_pass
      assign dout_o = din_i;
    end else begin : g_line
      pos_t line_q [DEPTH];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < DEPTH; i++) line_q[i] <= '0;
        end else if (clr_i) begin
          for (int i = 0; i < DEPTH; i++) line_q[i] <= '0;
        end else begin
          line_q[0] <= pos_t'(din_i);
          for (int i = 1; i < DEPTH; i++) line_q[i] <= line_q[i-1];
        end
      end

      assign dout_o = line_q[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/pen_locator.sv
// rtl/pen_locator.sv - correlates pen pulses with the scanned pixel and issues confirmed RAM writes
module pen_locator
  import pen_locator_pkg::*;
#(
  parameter int PEN_DELAY = PEN_DELAY_DEF,
  parameter int CONFIRM   = CONFIRM_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       pen_in,
  input  logic [7:0] led_row,
  input  logic [7:0] led_col,
  input  logic [1:0] pen_color,
  input  logic       erase,
  output logic       wr_en,
  output logic [2:0] wr_row,
  output logic [2:0] wr_col,
  output logic [3:0] wr_data,
  output logic       pen_valid,
  output logic [2:0] pen_row,
  output logic [2:0] pen_col
);

  localparam logic [2:0] CONF_MAX = 3'(CONFIRM);

  state_t     state_q, state_d;
  logic       pen_s1_q, pen_s2_q;
  oh_t        row_oh, col_oh;
  pos_t       cur_pos, dly_pos;
  logic [6:0] dly_raw;
  logic       track, boundary, hit, write_req;

  logic       prev_valid_q, prev_valid_d;
  logic [5:0] prev_pos_q, prev_pos_d;
  logic       cand_valid_q, cand_valid_d;
  logic [5:0] cand_pos_q, cand_pos_d;
  logic [5:0] last_pos_q, last_pos_d;
  logic [2:0] conf_cnt_q, conf_cnt_d;
  logic       pen_valid_q, pen_valid_d;
  logic [5:0] pen_pos_q, pen_pos_d;
  logic [5:0] wr_pos_q, wr_pos_d;
  logic [3:0] wr_data_q, wr_data_d;

  always_comb begin
    row_oh        = oh_encode(led_row);
    col_oh        = oh_encode(led_col);
    cur_pos.valid = row_oh.ok & col_oh.ok;
    cur_pos.pos   = {row_oh.idx, col_oh.idx};
  end

  assign track = en && (state_q != S_IDLE);

  pen_pos_delay #(.DEPTH(PEN_DELAY - 2)) u_delay (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (!track),
    .din_i  (cur_pos),
    .dout_o (dly_raw)
  );

  assign dly_pos  = pos_t'(dly_raw);
  assign boundary = dly_pos.valid && prev_valid_q && (dly_pos.pos < prev_pos_q);
  assign hit      = pen_s2_q && dly_pos.valid;

  always_comb begin
    prev_valid_d = prev_valid_q;
    prev_pos_d   = prev_pos_q;
    cand_valid_d = cand_valid_q;
    cand_pos_d   = cand_pos_q;
    last_pos_d   = last_pos_q;
    conf_cnt_d   = conf_cnt_q;
    pen_valid_d  = pen_valid_q;
    pen_pos_d    = pen_pos_q;
    wr_pos_d     = wr_pos_q;
    wr_data_d    = wr_data_q;
    write_req    = 1'b0;
    if (!track) begin
      prev_valid_d = 1'b0;
      prev_pos_d   = 6'd0;
      cand_valid_d = 1'b0;
      cand_pos_d   = 6'd0;
      conf_cnt_d   = 3'd0;
    end else begin
      if (dly_pos.valid) begin
        prev_valid_d = 1'b1;
        prev_pos_d   = dly_pos.pos;
      end
      if (boundary) begin
        if (!cand_valid_q) begin
          conf_cnt_d  = 3'd0;
          pen_valid_d = 1'b0;
        end else if (cand_pos_q == last_pos_q) begin
          if (conf_cnt_q < CONF_MAX) conf_cnt_d = conf_cnt_q + 3'd1;
        end else begin
          last_pos_d = cand_pos_q;
          conf_cnt_d = 3'd1;
        end
        // a moved pen restarts the count, so reaching CONFIRM there is a fresh write too
        write_req = cand_valid_q && (conf_cnt_d == CONF_MAX) &&
                    ((conf_cnt_q != CONF_MAX) || (cand_pos_q != last_pos_q));
        cand_valid_d = hit;
        cand_pos_d   = dly_pos.pos;
      end else if (hit && !cand_valid_q) begin
        cand_valid_d = 1'b1;
        cand_pos_d   = dly_pos.pos;
      end
      if (write_req) begin
        pen_valid_d = 1'b1;
        pen_pos_d   = cand_pos_q;
        wr_pos_d    = cand_pos_q;
        wr_data_d   = ram_word(erase, pen_color);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (en) state_d = S_TRACK;
      S_TRACK: if (!en) state_d = S_IDLE; else if (write_req) state_d = S_WRITE;
      S_WRITE: if (!en) state_d = S_IDLE; else if (write_req) state_d = S_WRITE; else state_d = S_TRACK;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      pen_s1_q     <= 1'b0;
      pen_s2_q     <= 1'b0;
      prev_valid_q <= 1'b0;
      prev_pos_q   <= 6'd0;
      cand_valid_q <= 1'b0;
      cand_pos_q   <= 6'd0;
      last_pos_q   <= 6'd0;
      conf_cnt_q   <= 3'd0;
      pen_valid_q  <= 1'b0;
      pen_pos_q    <= 6'd0;
      wr_pos_q     <= 6'd0;
      wr_data_q    <= 4'd0;
    end else begin
      state_q      <= state_d;
      pen_s1_q     <= pen_in;
      pen_s2_q     <= pen_s1_q;
      prev_valid_q <= prev_valid_d;
      prev_pos_q   <= prev_pos_d;
      cand_valid_q <= cand_valid_d;
      cand_pos_q   <= cand_pos_d;
      last_pos_q   <= last_pos_d;
      conf_cnt_q   <= conf_cnt_d;
      pen_valid_q  <= pen_valid_d;
      pen_pos_q    <= pen_pos_d;
      wr_pos_q     <= wr_pos_d;
      wr_data_q    <= wr_data_d;
    end
  end

  assign wr_en     = (state_q == S_WRITE);
  assign wr_row    = wr_pos_q[5:3];
  assign wr_col    = wr_pos_q[2:0];
  assign wr_data   = wr_data_q;
  assign pen_valid = pen_valid_q;
  assign pen_row   = pen_pos_q[5:3];
  assign pen_col   = pen_pos_q[2:0];

endmodule
